dac_sample_sched: RTL and testbench

Dual-channel sample scheduler sitting directly upstream of the TLV5638 serial DAC driver. Accepts 12-bit samples for DAC channels A and B on independent valid/ready ports, buffers each in a small FIFO, and presents one sample at a time on the driver's `data`/`ab` inputs. Holds each sample stable until the driver's `done` handshake confirms the serial write. Includes a watchdog so a stalled driver cannot hang the source.

---
 rtl/dac_pkg.sv | 16 +
 rtl/dac_sfifo.sv | 55 +++++
 rtl/dac_sample_sched.sv | 164 ++++++++++++++++
 tb/tb_dac_sample_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants for the DAC sample scheduler: sample width default,
// channel select encoding for the driver's ab input, and FSM state codes.
package dac_pkg;

    localparam int DW_DEF = 12;

    // Driver ab input: 1 selects DAC channel A, 0 selects channel B.
    localparam logic AB_A = 1'b1;
    localparam logic AB_B = 1'b0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

endpackage

// File: rtl/dac_sfifo.sv
// Small synchronous first-word-fall-through FIFO. Pointers carry one extra
// wrap bit so full and empty are distinguished without an occupancy counter.
module dac_sfifo
    import dac_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_50) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop in the same cycle both take effect.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Dual-channel sample scheduler feeding the TLV5638 serial DAC driver.
// Each channel is buffered in its own FIFO; samples are issued one at a time,
// alternating channels when both have data, and held until the driver's done
// line shows a full low-then-high cycle. A watchdog aborts a stalled write.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no write in flight; choose next channel if any FIFO has data
// ST_LOAD      | pop chosen FIFO onto dac_data/dac_ab, arm watchdog
// ST_WAIT_LOW  | wait for synchronized done to fall
// ST_WAIT_HIGH | wait for synchronized done to rise; write then complete
module dac_sample_sched
    import dac_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk_50,
    input  logic          rst,
    input  logic [DW-1:0] a_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] b_data,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [DW-1:0] dac_data,
    output logic          dac_ab,
    input  logic          dac_done,
    output logic          busy,
    output logic          err_timeout
);

    localparam int WW = $clog2(TIMEOUT + 1);

    logic [1:0]    state;
    logic          sel_ab;
    logic          last_ab;
    logic          pick_ab;
    logic [WW-1:0] wdog;

    logic          done_m;
    logic          done_s;
    logic          done_d;
    logic          done_fall;
    logic          done_rise;

    logic          a_full, a_empty, a_pop;
    logic          b_full, b_empty, b_pop;
    logic [DW-1:0] a_q, b_q;

    // Ready is forced low while reset is held so nothing is accepted into a
    // FIFO that is being flushed.
    assign a_ready = !rst && !a_full;
    assign b_ready = !rst && !b_full;

    assign a_pop = (state == ST_LOAD) && (sel_ab == AB_A);
    assign b_pop = (state == ST_LOAD) && (sel_ab == AB_B);

    assign busy = (state != ST_IDLE);

    assign done_fall = !done_s && done_d;
    assign done_rise = done_s && !done_d;

    dac_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_a (
        .clk_50    (clk_50),
        .rst       (rst),
        .push      (a_valid && a_ready),
        .push_data (a_data),
        .pop       (a_pop),
        .pop_data  (a_q),
        .full      (a_full),
        .empty     (a_empty)
    );

    dac_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_b (
        .clk_50    (clk_50),
        .rst       (rst),
        .push      (b_valid && b_ready),
        .push_data (b_data),
        .pop       (b_pop),
        .pop_data  (b_q),
        .full      (b_full),
        .empty     (b_empty)
    );

    // Bring the driver's done line into clk_50 and keep one delayed copy for edges.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            done_m <= 1'b0;
            done_s <= 1'b0;
            done_d <= 1'b0;
        end else begin
            done_m <= dac_done;
            done_s <= done_m;
            done_d <= done_s;
        end
    end

    // Round-robin pick: alternate when both channels wait, else take the one with data.
    always_comb begin
        pick_ab = AB_A;
        if (!a_empty && !b_empty) begin
            pick_ab = ~last_ab;
        end else if (!b_empty) begin
            pick_ab = AB_B;
        end
    end

    // Write sequencing, output holding registers and watchdog down-counter.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel_ab      <= AB_A;
            last_ab     <= AB_B;
            dac_data    <= '0;
            dac_ab      <= AB_A;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!a_empty || !b_empty) begin
                        sel_ab <= pick_ab;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    dac_data <= (sel_ab == AB_A) ? a_q : b_q;
                    dac_ab   <= sel_ab;
                    last_ab  <= sel_ab;
                    wdog     <= WW'(TIMEOUT - 1);
                    state    <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (wdog == '0) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog - 1'b1;
                        if (done_fall) begin
                            state <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (wdog == '0) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wdog <= wdog - 1'b1;
                        if (done_rise) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sample_sched.sv
// Bench for the DAC sample scheduler: directed corner cases, a vector table
// for service order, and randomized traffic against a queue-based model.
module tb_dac_sample_sched;

    localparam int DW      = 12;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 4096;

    logic          clk_50 = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [DW-1:0] b_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [DW-1:0] dac_data;
    logic          dac_ab;
    logic          dac_done = 1'b1;
    logic          busy;
    logic          err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    dac_sample_sched #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .a_data      (a_data),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b_data      (b_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .dac_data    (dac_data),
        .dac_ab      (dac_ab),
        .dac_done    (dac_done),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int i;
        i = 0;
        while (busy !== lvl && i < budget) begin
            tick();
            i++;
        end
        if (busy !== lvl) fail(name);
    endtask

    task automatic push(input logic ab, input logic [DW-1:0] d);
        int i;
        if (ab) begin
            a_valid = 1'b1;
            a_data  = d;
        end else begin
            b_valid = 1'b1;
            b_data  = d;
        end
        i = 0;
        while (((ab ? a_ready : b_ready) !== 1'b1) && i < 6000) begin
            tick();
            i++;
        end
        if (i >= 6000) fail("push_ready");
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic do_reset();
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        dac_done = 1'b1;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Driver-like done response: low for a few cycles, then high, then wait for completion.
    task automatic handshake(input string name);
        repeat (3) tick();
        dac_done = 1'b0;
        repeat (5) tick();
        dac_done = 1'b1;
        wait_busy(1'b0, 20, name);
    endtask

    task automatic serve(input logic exp_ab, input logic [DW-1:0] exp_d, input string name);
        wait_busy(1'b1, 6000, {name, "_start"});
        tick();
        chk({name, "_ab"}, 32'(dac_ab), 32'(exp_ab));
        chk({name, "_data"}, 32'(dac_data), 32'(exp_d));
        handshake({name, "_done"});
    endtask

    // Reference model: per-channel queues of accepted samples; on every write
    // start, the expected channel follows the alternate-when-both rule and the
    // expected word is the head of that queue.
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic          pend_a, pend_b;
    logic [DW-1:0] pend_a_d, pend_b_d;
    logic          last_m;
    logic          prev_busy;
    logic          exp_v;
    logic          exp_ab_m;
    logic [DW-1:0] exp_d_m;
    logic          ch;
    int            n_push, n_load;

    always @(negedge clk_50) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            pend_a    = 1'b0;
            pend_b    = 1'b0;
            last_m    = 1'b0;
            prev_busy = 1'b0;
            exp_v     = 1'b0;
            n_push    = 0;
            n_load    = 0;
        end else begin
            if (exp_v) begin
                chk("mon_ab", 32'(dac_ab), 32'(exp_ab_m));
                chk("mon_data", 32'(dac_data), 32'(exp_d_m));
                exp_v = 1'b0;
            end
            if (busy && !prev_busy) begin
                if (qa.size() == 0 && qb.size() == 0) begin
                    fail("mon_load_with_empty_queues");
                end else begin
                    if (qa.size() != 0 && qb.size() != 0) ch = ~last_m;
                    else ch = (qa.size() != 0);
                    exp_ab_m = ch;
                    exp_d_m  = ch ? qa.pop_front() : qb.pop_front();
                    last_m   = ch;
                    exp_v    = 1'b1;
                    n_load++;
                end
            end
            if (pend_a) qa.push_back(pend_a_d);
            if (pend_b) qb.push_back(pend_b_d);
            pend_a   = a_valid && a_ready;
            pend_b   = b_valid && b_ready;
            pend_a_d = a_data;
            pend_b_d = b_data;
            if (pend_a) n_push++;
            if (pend_b) n_push++;
            prev_busy = busy;
        end
    end

    typedef struct {
        logic          push_ab;
        logic [DW-1:0] push_d;
        logic          exp_ab;
        logic [DW-1:0] exp_d;
    } vec_t;

    vec_t vt[6];

    initial begin
        #(20 * 60000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vt[0] = '{1'b1, 12'h111, 1'b1, 12'h111};
        vt[1] = '{1'b1, 12'h222, 1'b0, 12'hAAA};
        vt[2] = '{1'b0, 12'hAAA, 1'b1, 12'h222};
        vt[3] = '{1'b0, 12'hBBB, 1'b0, 12'hBBB};
        vt[4] = '{1'b1, 12'h333, 1'b1, 12'h333};
        vt[5] = '{1'b1, 12'h444, 1'b1, 12'h444};

        // Reset values and first write timing
        tick();
        tick();
        chk("rst_dac_data", 32'(dac_data), 32'h0);
        chk("rst_dac_ab", 32'(dac_ab), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err_timeout), 32'h0);
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 32'h1);
        chk("post_rst_b_ready", 32'(b_ready), 32'h1);
        tick();
        push(1'b1, 12'h800);
        chk("t1_idle_after_push", 32'(busy), 32'h0);
        tick();
        chk("t1_load_busy", 32'(busy), 32'h1);
        chk("t1_data_before_load", 32'(dac_data), 32'h0);
        tick();
        chk("t1_data", 32'(dac_data), 32'h800);
        chk("t1_ab", 32'(dac_ab), 32'h1);
        dac_done = 1'b0;
        repeat (100) tick();
        chk("t1_busy_during_low", 32'(busy), 32'h1);
        dac_done = 1'b1;
        repeat (2) tick();
        chk("t1_busy_2_after_rise", 32'(busy), 32'h1);
        repeat (2) tick();
        chk("t1_busy_4_after_rise", 32'(busy), 32'h0);
        chk("t1_no_err", 32'(err_timeout), 32'h0);

        // Service order from the vector table
        do_reset();
        for (int i = 0; i < 6; i++) push(vt[i].push_ab, vt[i].push_d);
        for (int i = 0; i < 6; i++) serve(vt[i].exp_ab, vt[i].exp_d, $sformatf("order%0d", i));

        // Fill channel A with one word in flight
        do_reset();
        for (int i = 0; i < 5; i++) push(1'b1, 12'(12'h301 + i));
        chk("t3_a_full", 32'(a_ready), 32'h0);
        chk("t3_b_ready", 32'(b_ready), 32'h1);
        repeat (10) tick();
        chk("t3_a_still_full", 32'(a_ready), 32'h0);
        for (int i = 0; i < 5; i++) serve(1'b1, 12'(12'h301 + i), $sformatf("fill%0d", i));
        chk("t3_a_ready_after", 32'(a_ready), 32'h1);

        // Watchdog: done stays high for the whole write
        do_reset();
        push(1'b1, 12'h0AA);
        push(1'b1, 12'h0BB);
        wait_busy(1'b1, 10, "t4_load");
        tick();
        chk("t4_loaded", 32'(dac_data), 32'h0AA);
        repeat (TIMEOUT - 1) tick();
        chk("t4_err_before", 32'(err_timeout), 32'h0);
        chk("t4_busy_before", 32'(busy), 32'h1);
        tick();
        chk("t4_err_at_timeout", 32'(err_timeout), 32'h1);
        chk("t4_busy_at_timeout", 32'(busy), 32'h0);
        chk("t4_data_held", 32'(dac_data), 32'h0AA);
        serve(1'b1, 12'h0BB, "t4_next");
        chk("t4_err_sticky", 32'(err_timeout), 32'h1);

        // Reset while waiting for done to rise, three words queued
        do_reset();
        chk("t5_err_cleared", 32'(err_timeout), 32'h0);
        for (int i = 0; i < 4; i++) push(1'b1, 12'(12'h501 + i));
        repeat (3) tick();
        dac_done = 1'b0;
        repeat (8) tick();
        chk("t5_busy_wait_high", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        chk("t5_rst_data", 32'(dac_data), 32'h0);
        chk("t5_rst_ab", 32'(dac_ab), 32'h1);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_a_ready", 32'(a_ready), 32'h0);
        dac_done = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_a_ready_after", 32'(a_ready), 32'h1);
        repeat (20) tick();
        chk("t5_fifos_flushed", 32'(busy), 32'h0);

        // A high-only done pulse must not finish the write
        do_reset();
        dac_done = 1'b0;
        push(1'b1, 12'h601);
        push(1'b0, 12'h602);
        wait_busy(1'b1, 10, "t6_load");
        tick();
        repeat (3) tick();
        dac_done = 1'b1;
        repeat (5) tick();
        dac_done = 1'b0;
        repeat (10) tick();
        chk("t6_still_busy", 32'(busy), 32'h1);
        chk("t6_data_held", 32'(dac_data), 32'h601);
        dac_done = 1'b1;
        wait_busy(1'b0, 20, "t6_complete");
        serve(1'b0, 12'h602, "t6_next");

        // Randomized traffic against the queue model
        do_reset();
        fork
            begin
                repeat (400) begin
                    a_valid = ($urandom_range(0, 3) == 0);
                    a_data  = 12'($urandom_range(0, 4095));
                    b_valid = ($urandom_range(0, 3) == 0);
                    b_data  = 12'($urandom_range(0, 4095));
                    tick();
                end
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
            begin
                for (int w = 0; w < 1000; w++) begin
                    int i;
                    i = 0;
                    while (!busy && i < 300) begin
                        tick();
                        i++;
                    end
                    if (!busy) break;
                    repeat ($urandom_range(2, 5)) tick();
                    dac_done = 1'b0;
                    repeat ($urandom_range(1, 8)) tick();
                    dac_done = 1'b1;
                    wait_busy(1'b0, 20, "rand_complete");
                end
            end
        join
        chk("rand_traffic_seen", 32'(n_push > 20), 32'h1);
        chk("rand_all_served", 32'(n_load), 32'(n_push));
        chk("rand_queues_empty", 32'(qa.size() + qb.size()), 32'h0);
        chk("rand_no_err", 32'(err_timeout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
